// File: rtl/tt_um_sequential_divider_8by4_if.sv
// Pin bundle for the 8-by-4 sequential divider. The signal names are the
// Tiny Tapeout names, so the multiplier bench can drive this divider unchanged.
interface tt_um_sequential_divider_8by4_if;
  // Handshake: a start is taken on a rising edge where in_valid=1 while the
  // divider is idle or done. out_done is a one-cycle pulse. The result stays
  // on uo_out/uio_out/out_dbz until the next result is loaded.
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic       in_valid;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       out_done;
  logic       out_busy;
  logic       out_dbz;
  logic [1:0] dbg_state;

  modport master (
    output ui_in, uio_in, in_valid,
    input  uo_out, uio_out, uio_oe, out_done, out_busy, out_dbz, dbg_state
  );

  modport slave (
    input  ui_in, uio_in, in_valid,
    output uo_out, uio_out, uio_oe, out_done, out_busy, out_dbz, dbg_state
  );
endinterface

// File: rtl/tt_um_sequential_divider_8by4.sv
// Restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// Result registers hold the last result until the next one is loaded.
module tt_um_sequential_divider_8by4 #(
  parameter int DVD_W = 8,
  parameter int DVS_W = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  tt_um_sequential_divider_8by4_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int CNT_W = 4;

  state_e           state_q;
  logic [DVS_W-1:0] dvs_q;
  logic [DVD_W-1:0] q_q;
  logic [DVS_W:0]   r_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DVD_W-1:0] quo_q;
  logic [DVS_W-1:0] rem_q;
  logic             done_q;
  logic             busy_q;
  logic             dbz_q;

  logic [DVS_W:0]   r_shift;
  logic [DVS_W+1:0] diff;
  logic             borrow;
  logic [DVS_W:0]   r_step_d;
  logic [DVD_W-1:0] q_step_d;
  logic             start;
  logic [DVS_W-1:0] dvs_in;
  logic             unused_ok;

  assign dvs_in    = bus.uio_in[DVS_W-1:0];
  assign start     = bus.in_valid && (state_q != ST_RUN);
  assign unused_ok = ^bus.uio_in[7:DVS_W];

  // One restoring step. The extra top bit of diff carries the borrow.
  always_comb begin
    r_shift  = {r_q[DVS_W-1:0], q_q[DVD_W-1]};
    diff     = {1'b0, r_shift} - {2'b00, dvs_q};
    borrow   = diff[DVS_W+1];
    r_step_d = borrow ? r_shift : diff[DVS_W:0];
    q_step_d = {q_q[DVD_W-2:0], ~borrow};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dvs_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else if (start) begin
      if (dvs_in == '0) begin
        quo_q   <= '1;
        rem_q   <= '1;
        dbz_q   <= 1'b1;
        done_q  <= 1'b1;
        busy_q  <= 1'b0;
        state_q <= ST_DONE;
      end else begin
        dvs_q   <= dvs_in;
        q_q     <= bus.ui_in[DVD_W-1:0];
        r_q     <= '0;
        cnt_q   <= '0;
        done_q  <= 1'b0;
        busy_q  <= 1'b1;
        state_q <= ST_RUN;
      end
    end else if (state_q == ST_RUN) begin
      q_q   <= q_step_d;
      r_q   <= r_step_d;
      cnt_q <= cnt_q + 1'b1;
      // The remainder is always below the divisor here, so its top bit is zero.
      if (cnt_q == CNT_W'(DVD_W - 1)) begin
        quo_q   <= q_step_d;
        rem_q   <= r_step_d[DVS_W-1:0];
        dbz_q   <= 1'b0;
        done_q  <= 1'b1;
        busy_q  <= 1'b0;
        state_q <= ST_DONE;
      end
    end else begin
      done_q  <= 1'b0;
      state_q <= ST_IDLE;
    end
  end

  assign bus.uo_out    = quo_q;
  assign bus.uio_out   = {rem_q, {(8 - DVS_W){1'b0}}};
  assign bus.uio_oe    = 8'hF0;
  assign bus.out_done  = done_q;
  assign bus.out_busy  = busy_q;
  assign bus.out_dbz   = dbz_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_tt_um_sequential_divider_8by4.sv
// Directed and random bench for the sequential 8-by-4 divider.
module tb_tt_um_sequential_divider_8by4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  tt_um_sequential_divider_8by4_if bus();

  tt_um_sequential_divider_8by4 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse a start, then step until out_done. edges counts the start edge too.
  task automatic run_div(input logic [7:0] dvd, input logic [7:0] uio,
                         output int edges, output int busy_n);
    bus.ui_in    = dvd;
    bus.uio_in   = uio;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.ui_in    = 8'($urandom);
    bus.uio_in   = 8'($urandom);
    edges  = 1;
    busy_n = int'(bus.out_busy);
    while (!bus.out_done && edges < 20) begin
      tick();
      edges++;
      busy_n += int'(bus.out_busy);
    end
    if (!bus.out_done) edges = 99;
  endtask

  task automatic test_reset();
    bus.ui_in    = 8'd54;
    bus.uio_in   = 8'h06;
    bus.in_valid = 1'b1;
    reset = 1'b0;
    tick();
    tick();
    checks++; if (bus.uo_out !== 8'h00) begin failures++; $display("FAIL reset_uo_out got=%0h exp=0", bus.uo_out); end
    checks++; if (bus.uio_out !== 8'h00) begin failures++; $display("FAIL reset_uio_out got=%0h exp=0", bus.uio_out); end
    checks++; if (bus.uio_oe !== 8'hF0) begin failures++; $display("FAIL reset_uio_oe got=%0h exp=f0", bus.uio_oe); end
    checks++; if ({bus.out_done, bus.out_busy, bus.out_dbz} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {bus.out_done, bus.out_busy, bus.out_dbz}); end
    checks++; if (bus.dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.dbg_state); end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    checks++; if (bus.out_busy !== 1'b0) begin failures++; $display("FAIL reset_no_start got=%b exp=0", bus.out_busy); end
  endtask

  task automatic test_basic();
    int e, b;
    run_div(8'd54, 8'h06, e, b);
    checks++; if (e != 9) begin failures++; $display("FAIL basic_latency got=%0d exp=9", e); end
    checks++; if (b != 8) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=8", b); end
    checks++; if (bus.uo_out !== 8'd9) begin failures++; $display("FAIL basic_quo got=%0d exp=9", bus.uo_out); end
    checks++; if (bus.uio_out !== 8'h00) begin failures++; $display("FAIL basic_rem got=%0h exp=0", bus.uio_out); end
    checks++; if (bus.out_dbz !== 1'b0) begin failures++; $display("FAIL basic_dbz got=%b exp=0", bus.out_dbz); end
    checks++; if (bus.uio_oe !== 8'hF0) begin failures++; $display("FAIL basic_uio_oe got=%0h exp=f0", bus.uio_oe); end
    tick();
    checks++; if (bus.out_done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", bus.out_done); end
    checks++; if (bus.uo_out !== 8'd9) begin failures++; $display("FAIL basic_quo_hold got=%0d exp=9", bus.uo_out); end
  endtask

  task automatic test_vectors();
    logic [7:0] dvd_t [4] = '{8'd225, 8'd200, 8'd255, 8'd3};
    logic [7:0] dvs_t [4] = '{8'h0F,  8'h07,  8'h01,  8'h09};
    logic [7:0] quo_t [4] = '{8'd15,  8'd28,  8'd255, 8'd0};
    logic [7:0] uio_t [4] = '{8'h00,  8'h40,  8'h00,  8'h30};
    int e, b;
    for (int i = 0; i < 4; i++) begin
      run_div(dvd_t[i], dvs_t[i] | 8'hA0, e, b);
      checks++; if (e != 9) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=9", i, e); end
      checks++; if (bus.uo_out !== quo_t[i]) begin failures++; $display("FAIL vec%0d_quo got=%0d exp=%0d", i, bus.uo_out, quo_t[i]); end
      checks++; if (bus.uio_out !== uio_t[i]) begin failures++; $display("FAIL vec%0d_rem got=%0h exp=%0h", i, bus.uio_out, uio_t[i]); end
      tick();
    end
  endtask

  task automatic test_dbz();
    int e, b;
    run_div(8'd13, 8'h00, e, b);
    checks++; if (e != 1) begin failures++; $display("FAIL dbz_latency got=%0d exp=1", e); end
    checks++; if (b != 0) begin failures++; $display("FAIL dbz_busy got=%0d exp=0", b); end
    checks++; if (bus.uo_out !== 8'hFF) begin failures++; $display("FAIL dbz_quo got=%0h exp=ff", bus.uo_out); end
    checks++; if (bus.uio_out !== 8'hF0) begin failures++; $display("FAIL dbz_rem got=%0h exp=f0", bus.uio_out); end
    checks++; if (bus.out_dbz !== 1'b1) begin failures++; $display("FAIL dbz_flag got=%b exp=1", bus.out_dbz); end
    tick();
    checks++; if (bus.out_done !== 1'b0) begin failures++; $display("FAIL dbz_done_pulse got=%b exp=0", bus.out_done); end
    checks++; if (bus.out_dbz !== 1'b1) begin failures++; $display("FAIL dbz_flag_hold got=%b exp=1", bus.out_dbz); end
    run_div(8'd20, 8'h05, e, b);
    checks++; if (bus.out_dbz !== 1'b0) begin failures++; $display("FAIL dbz_clear got=%b exp=0", bus.out_dbz); end
    checks++; if (bus.uo_out !== 8'd4) begin failures++; $display("FAIL dbz_next_quo got=%0d exp=4", bus.uo_out); end
    checks++; if (bus.uio_out !== 8'h00) begin failures++; $display("FAIL dbz_next_rem got=%0h exp=0", bus.uio_out); end
    tick();
  endtask

  task automatic test_reset_abort();
    int e, b;
    int done_seen;
    bus.ui_in    = 8'd100;
    bus.uio_in   = 8'h03;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (bus.uo_out !== 8'h00) begin failures++; $display("FAIL abort_uo_out got=%0h exp=0", bus.uo_out); end
    checks++; if (bus.uio_out !== 8'h00) begin failures++; $display("FAIL abort_uio_out got=%0h exp=0", bus.uio_out); end
    checks++; if ({bus.out_done, bus.out_busy, bus.out_dbz} !== 3'b000) begin failures++; $display("FAIL abort_flags got=%b exp=000", {bus.out_done, bus.out_busy, bus.out_dbz}); end
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      done_seen += int'(bus.out_done);
    end
    checks++; if (done_seen != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_seen); end
    run_div(8'd100, 8'h03, e, b);
    checks++; if (e != 9) begin failures++; $display("FAIL abort_retry_latency got=%0d exp=9", e); end
    checks++; if (bus.uo_out !== 8'd33) begin failures++; $display("FAIL abort_retry_quo got=%0d exp=33", bus.uo_out); end
    checks++; if (bus.uio_out !== 8'h10) begin failures++; $display("FAIL abort_retry_rem got=%0h exp=10", bus.uio_out); end
    tick();
  endtask

  task automatic test_back_to_back();
    int e;
    bus.ui_in    = 8'd9;
    bus.uio_in   = 8'h03;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    e = 1;
    while (!bus.out_done && e < 20) begin
      tick();
      e++;
    end
    checks++; if (e != 9) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=9", e); end
    checks++; if (bus.uo_out !== 8'd3) begin failures++; $display("FAIL b2b_first_quo got=%0d exp=3", bus.uo_out); end
    checks++; if (bus.uio_out !== 8'h00) begin failures++; $display("FAIL b2b_first_rem got=%0h exp=0", bus.uio_out); end
    bus.ui_in    = 8'd54;
    bus.uio_in   = 8'h06;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_done !== 1'b0) begin failures++; $display("FAIL b2b_done_pulse got=%b exp=0", bus.out_done); end
    checks++; if (bus.out_busy !== 1'b1) begin failures++; $display("FAIL b2b_restart_busy got=%b exp=1", bus.out_busy); end
    checks++; if (bus.uo_out !== 8'd3) begin failures++; $display("FAIL b2b_quo_hold got=%0d exp=3", bus.uo_out); end
    e = 1;
    while (!bus.out_done && e < 20) begin
      if (e == 3) begin
        bus.ui_in    = 8'd255;
        bus.uio_in   = 8'h01;
        bus.in_valid = 1'b1;
      end
      tick();
      bus.in_valid = 1'b0;
      e++;
    end
    checks++; if (e != 9) begin failures++; $display("FAIL b2b_second_spacing got=%0d exp=9", e); end
    checks++; if (bus.uo_out !== 8'd9) begin failures++; $display("FAIL b2b_second_quo got=%0d exp=9", bus.uo_out); end
    checks++; if (bus.uio_out !== 8'h00) begin failures++; $display("FAIL b2b_second_rem got=%0h exp=0", bus.uio_out); end
    tick();
    checks++; if (bus.out_done !== 1'b0) begin failures++; $display("FAIL b2b_second_pulse got=%b exp=0", bus.out_done); end
    tick();
    checks++; if (bus.out_busy !== 1'b0) begin failures++; $display("FAIL b2b_no_queued_start got=%b exp=0", bus.out_busy); end
  endtask

  task automatic test_random();
    int e, b;
    int dvd, dvs, quo, rem;
    for (int i = 0; i < 200; i++) begin
      dvd = $urandom_range(0, 255);
      dvs = $urandom_range(1, 15);
      run_div(8'(dvd), 8'(dvs) | 8'(($urandom_range(0, 15)) << 4), e, b);
      quo = int'(bus.uo_out);
      rem = int'(bus.uio_out[7:4]);
      checks++; if (e != 9) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=9", i, e); end
      checks++; if (quo != dvd / dvs || rem != dvd % dvs) begin failures++; $display("FAIL rand%0d_model %0d/%0d got q=%0d r=%0d exp q=%0d r=%0d", i, dvd, dvs, quo, rem, dvd / dvs, dvd % dvs); end
      checks++; if (quo * dvs + rem != dvd || rem >= dvs || bus.uio_out[3:0] !== 4'h0) begin failures++; $display("FAIL rand%0d_invariant %0d/%0d got q=%0d uio=%0h", i, dvd, dvs, quo, bus.uio_out); end
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    bus.ui_in    = 8'h00;
    bus.uio_in   = 8'h00;
    bus.in_valid = 1'b0;
    test_reset();
    test_basic();
    test_vectors();
    test_dbz();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
